hello_wbmaster: RTL and testbench
=================================

Name: hello_wbmaster

Overview:
Autonomous Wishbone master that sits directly upstream of the hello LED slave on the conbus. On a programmable period it issues a write cycle carrying an incrementing pattern (bit 0 drives the LED), then optionally a read-back cycle. It also watches for a missing ack with a bus-timeout, so the slave can be exercised in simulation and on the board without the CPU.

Parameters:
PERIOD, 50000000, sys_clk cycles between transaction starts (>=2)
TARGET_ADR, 32'h60000000, byte address driven on wb_adr_o for both cycles
READBACK, 1, 1 = read cycle follows every write; 0 = write only
TIMEOUT, 16, max cycles stb may stay asserted without ack (>=2)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
enable  in  1  run control; low = stop after the current transaction
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  4  byte selects, constant 4'hf
wb_ack_i  in  1  Wishbone acknowledge
pattern  out  32  last successfully written value
rd_data  out  32  last read-back value
err_timeout  out  1  sticky, set on any bus timeout
busy  out  1  high while not in IDLE

Behaviour:
- Clock: one clock, sys_clk. Reset: sys_rst, asynchronous and active-high.
- Reset values: all outputs 0, except wb_adr_o = TARGET_ADR and wb_sel_o = 4'hf. Internal tick counter = 0, pending = 0, state = IDLE. Assertion mid-cycle drops cyc/stb immediately.
- All bus outputs are registered.
- Tick counter: counts 0..PERIOD-1 while enable = 1, then wraps. Tick pulse is generated on the terminal count. enable = 0 holds the counter at 0.
- pending flag:
  - Set by a tick while busy.
  - Cleared when IDLE consumes it.
  - One deep: extra ticks while pending are dropped.
- FSM states are IDLE, WR, RD.
- IDLE:
  - If (tick | pending) & enable: go to WR.
  - On entry to WR: cyc = stb = we = 1, wb_dat_o = pattern+1, timeout counter = 0.
- WR:
  - On the edge sampling ack = 1: pattern <= wb_dat_o.
  - If READBACK: go to RD with we = 0, cyc/stb kept high, timeout counter = 0.
  - Else: drop cyc/stb and go to IDLE.
- RD:
  - On ack: rd_data <= wb_dat_i, drop cyc/stb, go to IDLE.
- Timeout (WR or RD):
  - Timeout counter increments each cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: drop cyc/stb, set err_timeout, go to IDLE.
  - pattern is not updated on a WR timeout.
  - If ack and the timeout condition occur in the same cycle, ack wins.
- Handshake: cyc and stb always move together. At most one transaction is outstanding. Single-cycle ack is supported, and a cycle is ended on the same edge that samples ack.
- enable falling mid-transaction: the current WR/RD (and the following RD) completes; then the FSM stays in IDLE with pending cleared.
- pattern arithmetic: 32-bit, wraps 32'hffffffff -> 0.

Decomposition:
- Shared package hello_pkg:
  - FSM state encodings IDLE/WR/RD (2 bits)
  - WB_SEL_ALL = 4'hf
  - default TARGET_ADR
- One natural sub-module: hello_tick (period counter plus enable gating, emits the tick pulse).

Test Plan:
- PERIOD=4, READBACK=0, slave acks 1 cycle after stb: writes of 1, 2, 3 appear every 4 cycles; pattern follows; cyc high exactly 2 cycles each.
- READBACK=1, slave returns 32'hdeadbeef with 3-cycle read latency: WR then RD back-to-back with cyc continuously high; rd_data = 32'hdeadbeef; busy high for the whole sequence.
- Slave never acks, TIMEOUT=8: cyc drops after 8 stb cycles; err_timeout = 1 and stays set; pattern is unchanged; the next tick retries with the same wb_dat_o value.
- PERIOD=2 with 5-cycle ack latency: ticks arriving while busy set pending once; the next transaction starts 1 cycle after IDLE; no transaction is lost or duplicated beyond one.
- enable deasserted during the WR wait: WR and RD complete, then no further cycles occur and the tick counter stays at 0.
- sys_rst pulsed mid-RD: cyc/stb drop asynchronously; all outputs return to reset values; after release the first write carries 1.

Source files
------------

// File: rtl/hello_wbmaster_pkg.sv
// rtl/hello_wbmaster_pkg.sv - shared types and constants for the hello Wishbone master
package hello_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL     = 4'hf;
  localparam logic [31:0] DEF_TARGET_ADR = 32'h6000_0000;

endpackage

// File: rtl/hello_wbmaster_if.sv
// rtl/hello_wbmaster_if.sv - Wishbone classic bus between the hello master and its slave
interface hello_wbmaster_if;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/hello_wbmaster_tick.sv
// rtl/hello_wbmaster_tick.sv - period counter; pulses o_tick on the terminal count while enabled
module hello_tick #(
  parameter int unsigned PERIOD = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] r_cnt;

  // Disabling parks the counter at 0 so a restart always sees a full period.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (!i_enable || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/hello_wbmaster.sv
// rtl/hello_wbmaster.sv - periodic write (plus optional read-back) master with bus timeout
module hello_wbmaster
  import hello_pkg::*;
#(
  parameter int unsigned PERIOD     = 50000000,
  parameter logic [31:0] TARGET_ADR = DEF_TARGET_ADR,
  parameter bit          READBACK   = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  hello_wbmaster_if.master wb,
  output logic [31:0]      pattern,
  output logic [31:0]      rd_data,
  output logic             err_timeout,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_pending;
  logic [TW-1:0] r_tcnt;
  logic          r_cyc;
  logic          r_we;
  logic [31:0]   r_dat;
  logic [31:0]   r_pattern;
  logic [31:0]   r_rd_data;
  logic          r_err;
  logic          w_tick;
  logic          w_expire;

  hello_tick #(.PERIOD(PERIOD)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  // Ack on the same edge as the timeout threshold takes priority.
  assign w_expire = !wb.wb_ack_i && (r_tcnt == TO_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_tcnt    <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_dat     <= '0;
      r_pattern <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_tick && r_state != ST_IDLE) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_pending <= 1'b0;
          if (enable && (w_tick || r_pending)) begin
            r_state <= ST_WR;
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_dat   <= r_pattern + 32'd1;
            r_tcnt  <= '0;
          end
        end
        ST_WR, ST_RD: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (wb.wb_ack_i) begin
            r_tcnt <= '0;
            r_we   <= 1'b0;
            if (r_state == ST_WR) begin
              r_pattern <= r_dat;
              if (READBACK) begin
                r_state <= ST_RD;
              end else begin
                r_state <= ST_IDLE;
                r_cyc   <= 1'b0;
              end
            end else begin
              r_rd_data <= wb.wb_dat_i;
              r_state   <= ST_IDLE;
              r_cyc     <= 1'b0;
            end
          end else if (w_expire) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign wb.wb_adr_o = TARGET_ADR;
  assign wb.wb_sel_o = WB_SEL_ALL;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = r_we;
  assign pattern     = r_pattern;
  assign rd_data     = r_rd_data;
  assign err_timeout = r_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hello_wbmaster.sv
// tb/tb_hello_wbmaster.sv - randomized self-checking bench for hello_wbmaster against a transaction model
module tb_hello_wbmaster;

  localparam int unsigned A_PERIOD  = 4;
  localparam int unsigned A_TIMEOUT = 8;
  localparam int unsigned B_PERIOD  = 2;
  localparam int unsigned B_TIMEOUT = 16;
  localparam logic [31:0] A_ADR     = 32'h6000_0010;
  localparam logic [31:0] B_ADR     = 32'h6000_0000;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  always #5 clk = ~clk;

  hello_wbmaster_if wa ();
  hello_wbmaster_if wb_i ();

  logic [31:0] pat_a, rd_a, pat_b, rd_b;
  logic        err_a, busy_a, err_b, busy_b;

  hello_wbmaster #(.PERIOD(A_PERIOD), .TARGET_ADR(A_ADR), .READBACK(1'b0), .TIMEOUT(A_TIMEOUT)) u_a (
    .sys_clk(clk), .sys_rst(rst), .enable(en_a), .wb(wa),
    .pattern(pat_a), .rd_data(rd_a), .err_timeout(err_a), .busy(busy_a)
  );

  hello_wbmaster #(.PERIOD(B_PERIOD), .READBACK(1'b1), .TIMEOUT(B_TIMEOUT)) u_b (
    .sys_clk(clk), .sys_rst(rst), .enable(en_b), .wb(wb_i),
    .pattern(pat_b), .rd_data(rd_b), .err_timeout(err_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: op 0 = no bus cycle, 1 = write, 2 = read.
  typedef struct packed {
    int          run;
    logic        pend;
    int          op;
    int          held;
    logic [31:0] pat;
    logic [31:0] rd;
    logic [31:0] dat;
    logic        err;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.run = 0; m.pend = 1'b0; m.op = 0; m.held = 0;
    m.pat = '0; m.rd = '0; m.dat = '0; m.err = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t s, input int period, input int tmo, input bit rb,
                                        input bit en, input bit ack, input logic [31:0] di);
    model_t n;
    bit tick;
    n    = s;
    tick = en && ((s.run % period) == period - 1);
    n.run = en ? s.run + 1 : 0;
    if (s.op == 0) begin
      n.pend = 1'b0;
      if (en && (tick || s.pend)) begin
        n.op = 1; n.dat = s.pat + 32'd1; n.held = 0;
      end
    end else begin
      if (tick) n.pend = 1'b1;
      n.held = s.held + 1;
      if (ack) begin
        n.held = 0;
        if (s.op == 1) begin
          n.pat = s.dat;
          n.op  = rb ? 2 : 0;
        end else begin
          n.rd = di;
          n.op = 0;
        end
      end else if (s.held + 1 >= tmo) begin
        n.op = 0; n.err = 1'b1;
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  initial begin
    ma = model_reset();
    mb = model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ma = model_reset();
        mb = model_reset();
      end else begin
        ma = model_step(ma, A_PERIOD, A_TIMEOUT, 1'b0, en_a, wa.wb_ack_i, wa.wb_dat_i);
        mb = model_step(mb, B_PERIOD, B_TIMEOUT, 1'b1, en_b, wb_i.wb_ack_i, wb_i.wb_dat_i);
      end
    end
  end

  // Slave: ack arrives once stb has been seen for more than lat cycles.
  int          lat_a_wr = 1, lat_b_wr = 1, lat_b_rd = 3;
  int          cnt_a = 0, cnt_b = 0;
  bit          rand_rd = 1'b0;
  logic [31:0] rdval_b = 32'hdeadbeef;

  task automatic slave_step(input logic stb, input logic we, input logic ack_in, input int cnt_in,
                            input int lwr, input int lrd, output logic ack_out, output int cnt_out);
    ack_out = 1'b0;
    cnt_out = 0;
    if (!ack_in && stb) begin
      cnt_out = cnt_in + 1;
      if (cnt_out > (we ? lwr : lrd)) begin
        ack_out = 1'b1;
        cnt_out = 0;
      end
    end
  endtask

  initial begin
    logic ack_n;
    int   cnt_n;
    wa.wb_ack_i = 1'b0; wa.wb_dat_i = '0;
    wb_i.wb_ack_i = 1'b0; wb_i.wb_dat_i = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        wa.wb_ack_i = 1'b0; wb_i.wb_ack_i = 1'b0;
        cnt_a = 0; cnt_b = 0;
      end else begin
        #1;
        slave_step(wa.wb_stb_o, wa.wb_we_o, wa.wb_ack_i, cnt_a, lat_a_wr, lat_a_wr, ack_n, cnt_n);
        wa.wb_ack_i = ack_n; cnt_a = cnt_n;
        slave_step(wb_i.wb_stb_o, wb_i.wb_we_o, wb_i.wb_ack_i, cnt_b, lat_b_wr, lat_b_rd, ack_n, cnt_n);
        wb_i.wb_ack_i = ack_n; cnt_b = cnt_n;
        if (ack_n && !wb_i.wb_we_o) wb_i.wb_dat_i = rand_rd ? $urandom : rdval_b;
      end
    end
  end

  task automatic cmp(input string p, input model_t m, input logic [31:0] adr_exp,
                     input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] pat,
                     input logic [31:0] rd, input logic err, input logic busy);
    chk({p, "_cyc"},  cyc,  m.op != 0);
    chk({p, "_stb"},  stb,  m.op != 0);
    chk({p, "_we"},   we,   m.op == 1);
    chk({p, "_busy"}, busy, m.op != 0);
    chk({p, "_dat"},  dat,  m.dat);
    chk({p, "_pat"},  pat,  m.pat);
    chk({p, "_rd"},   rd,   m.rd);
    chk({p, "_err"},  err,  m.err);
    chk({p, "_adr"},  adr,  adr_exp);
    chk({p, "_sel"},  sel,  4'hf);
  endtask

  int          cyc_n = 0;
  int          a_len = 0, b_len = 0;
  bit          b_sw = 1'b0, b_sr = 1'b0;
  int          b_rises = 0, b_contig = 0;
  int          a_starts[$];
  int          a_lens[$];
  logic [31:0] a_dats[$];
  logic [31:0] b_dats[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      cmp("a", ma, A_ADR, wa.wb_cyc_o, wa.wb_stb_o, wa.wb_we_o, wa.wb_sel_o, wa.wb_adr_o,
          wa.wb_dat_o, pat_a, rd_a, err_a, busy_a);
      cmp("b", mb, B_ADR, wb_i.wb_cyc_o, wb_i.wb_stb_o, wb_i.wb_we_o, wb_i.wb_sel_o, wb_i.wb_adr_o,
          wb_i.wb_dat_o, pat_b, rd_b, err_b, busy_b);
      if (wa.wb_cyc_o) begin
        if (a_len == 0) begin
          a_starts.push_back(cyc_n);
          a_dats.push_back(wa.wb_dat_o);
        end
        a_len++;
      end else if (a_len != 0) begin
        a_lens.push_back(a_len);
        a_len = 0;
      end
      if (wb_i.wb_cyc_o) begin
        if (b_len == 0) begin
          b_rises++;
          b_dats.push_back(wb_i.wb_dat_o);
          b_sw = 1'b0; b_sr = 1'b0;
        end
        b_len++;
        if (wb_i.wb_we_o) b_sw = 1'b1; else b_sr = 1'b1;
      end else if (b_len != 0) begin
        if (b_sw && b_sr) b_contig++;
        b_len = 0;
      end
    end
  end

  function automatic logic [31:0] qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_logs();
    a_starts.delete(); a_lens.delete(); a_dats.delete(); b_dats.delete();
  endtask

  initial begin
    logic [31:0] p0;
    int          k, rises0, contig0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_adr_a", wa.wb_adr_o, A_ADR);
    chk("rst_adr_b", wb_i.wb_adr_o, B_ADR);
    chk("rst_sel_a", wa.wb_sel_o, 4'hf);
    chk("rst_cyc_a", wa.wb_cyc_o, 1'b0);
    chk("rst_pat_b", pat_b, 32'd0);
    chk("rst_err_a", err_a, 1'b0);
    rst = 1'b0; en_a = 1'b1; en_b = 1'b1;

    // Write-only cadence on A, back-to-back write/read on B.
    repeat (40) @(posedge clk);
    #1 en_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("p1_wdata", qd(a_dats, i), i + 1);
      chk("p1_cyc_len", qi(a_lens, i), 32'd2);
    end
    for (int i = 1; i < 3; i++) chk("p1_spacing", qi(a_starts, i) - qi(a_starts, i - 1), 32'd4);
    chk("p1_pattern", pat_a, a_dats.size());
    chk("p1_rd_data", rd_b, 32'hdeadbeef);
    chk("p1_contig", b_contig > 0, 1'b1);

    // A never acks; B runs with long latency so ticks pile up while busy.
    clear_logs();
    lat_a_wr = 1000; lat_b_wr = 5; lat_b_rd = 5; rand_rd = 1'b1;
    p0 = pat_a;
    en_a = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("p2_stb_len", qi(a_lens, 0), A_TIMEOUT);
    chk("p2_err", err_a, 1'b1);
    chk("p2_pattern", pat_a, p0);
    chk("p2_first_dat", qd(a_dats, 0), p0 + 32'd1);
    chk("p2_retry_dat", qd(a_dats, 1), p0 + 32'd1);
    chk("p2_b_err", err_b, 1'b0);
    for (int i = 1; i < b_dats.size(); i++) chk("p2_b_seq", b_dats[i], b_dats[i - 1] + 32'd1);
    lat_a_wr = 1;

    // Drop B's enable while a write is waiting for ack.
    k = 0;
    while (!(wb_i.wb_cyc_o && wb_i.wb_we_o) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("p3_found_wr", k < 50, 1'b1);
    @(posedge clk);
    #1 en_b = 1'b0;
    rises0 = b_rises; contig0 = b_contig;
    repeat (40) @(posedge clk);
    #1;
    chk("p3_no_new_cycle", b_rises, rises0);
    chk("p3_completed", b_contig, contig0 + 1);
    chk("p3_tick_cnt", u_b.u_tick.r_cnt, 0);
    chk("p3_busy", busy_b, 1'b0);
    chk("p3_err_sticky", err_a, 1'b1);

    // Reset asserted in the middle of a read cycle.
    lat_b_wr = 1; lat_b_rd = 3; rand_rd = 1'b0;
    en_b = 1'b1;
    k = 0;
    while (!(wb_i.wb_cyc_o && !wb_i.wb_we_o) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("p4_found_rd", k < 50, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("p4_cyc_async", wb_i.wb_cyc_o, 1'b0);
    chk("p4_stb_async", wb_i.wb_stb_o, 1'b0);
    chk("p4_pat_rst", pat_b, 32'd0);
    chk("p4_err_rst", err_a, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    k = 0;
    while ((b_dats.size() == 0 || a_dats.size() == 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("p4_restart", k < 100, 1'b1);
    chk("p4_first_b", qd(b_dats, 0), 32'd1);
    chk("p4_first_a", qd(a_dats, 0), 32'd1);

    // Random enables and latencies, including timeouts and single-cycle acks.
    rand_rd = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) en_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) en_b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        lat_a_wr = $urandom_range(0, 9);
        lat_b_wr = $urandom_range(0, 17);
        lat_b_rd = $urandom_range(0, 17);
      end
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach the end, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
